uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit shift register (PISO, start/stop framed) between NUM_REQ byte producers in the hub.
- Runs on the system clock, arbitrates round-robin, latches the winner's byte, and drives the shifter's new_data/char inputs.
- Watches the shifter's rdy to sequence bytes, with an optional lock for multi-byte messages.
- Sits between hub input channels and the single serial output pin.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- WIDTH, 8: character width; must match the shifter.
- SYNC_STAGES, 2: flops in the tx_rdy synchronizer, because the shifter runs on the UART clock domain.
- PREFIX_BASE, 8'h30: channel-ID base byte, used only with UART_ARB_PREFIX_EN.

Ports:
- clk  input  1  system clock (16 MHz).
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester byte-valid.
- data  input  NUM_REQ*WIDTH  flattened bytes; requester i owns bits [i*WIDTH +: WIDTH].
- lock  input  NUM_REQ  keep the grant after the current byte while req[i] stays high.
- ack  output  NUM_REQ  one-cycle pulse: data[i] captured.
- grant  output  NUM_REQ  one-hot current owner; zero when idle.
- tx_start  output  1  to shifter new_data; level-held until accepted.
- tx_char  output  WIDTH  to shifter char; stable while tx_start=1.
- tx_rdy  input  1  from shifter rdy (async domain).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset state: state=IDLE, ack=0, grant=0, tx_start=0, tx_char=0, busy=0, RR pointer=0, synchronizer flops=1 (idle line).
- rdy_s: tx_rdy after SYNC_STAGES flops. All decisions use rdy_s only.
- Round-robin: search req starting at the pointer, ascending, wrapping. The winner is the first set bit. On release, pointer = owner+1 mod NUM_REQ.
- States:
  - IDLE: if rdy_s=1 and req!=0, pick winner w at the clock edge. Load tx_char<=data[w], set grant[w], set ack[w] for the next cycle only, go SEND. Otherwise stay.
  - SEND: tx_start=1. When rdy_s=0 (shifter accepted), go to WAIT with tx_start=0 registered on that edge.
  - WAIT: when rdy_s=1, check the owner.
    - If lock[w]=1 and req[w]=1: load data[w], pulse ack[w], go SEND. No arbitration; grant is held.
    - Otherwise: grant=0, update pointer, go IDLE.
- Latency: req asserted in IDLE with rdy_s=1 gives ack and tx_start high in the next cycle.
- Requester contract:
  - Hold req and data stable until ack is seen.
  - In the ack cycle, the requester may present its next byte or drop req. That cycle is never sampled, because the arbiter is in SEND.
- Boundary conditions:
  - Simultaneous requests resolve by pointer only. Fixed priority is never used.
  - If req[w] drops while locked, the grant is released at the next WAIT exit.
  - If lock rises after the last ack, it takes effect at WAIT exit.
  - Reset mid-byte: outputs return to reset values immediately. The shifter finishes its frame on its own, and the arbiter waits for rdy_s=1 before the next grant.
  - tx_rdy already low at reset release: IDLE does not grant until rdy_s=1.
  - req bits of a non-owner during SEND/WAIT are ignored and cause no ack.

Optional Feature:
- Macro: UART_ARB_PREFIX_EN.
- With the macro defined:
  - Each fresh grant (from IDLE, not a lock continuation) first transmits PREFIX_BASE+w, then the latched requester byte.
  - The requester's byte is captured into a hold register and acked at grant time, with the same timing as without the macro.
  - State path: IDLE -> PSEND -> PWAIT -> SEND -> WAIT.
  - Locked continuations send no prefix.
- Without the macro: there are no prefix states and no hold register, and exactly one frame is sent per ack.

Test Plan:
- Reset, then req=4'b0001, data0=8'h55, tx_rdy model=1: ack[0] is pulsed one cycle. tx_char=8'h55 and tx_start=1 until the model drops rdy. busy returns to 0 after rdy returns.
- req=4'b1111 held, lock=0: grant order is 0,1,2,3,0. Each ack occurs exactly once per frame, and none occur while busy.
- req[2]=1, lock[2]=1, three bytes 8'hA1, 8'hA2, 8'hA3, with req[0]=1 pending: all three are sent before requester 0. The pointer is then 3, so requester 0 is granted next after wrap.
- Assert rst while in WAIT: tx_start=0, grant=0, ack=0 in the same cycle. After release with tx_rdy=1, req[1] is granted first only after rdy_s=1.
- Hold tx_rdy=0 at reset release with req=4'b0010: no ack until tx_rdy=1 has passed through 2 sync flops.
- With UART_ARB_PREFIX_EN, req[3]=1, data3=8'h41: frames are 8'h33 then 8'h41. ack[3] is pulsed once, on the grant cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit shifter among NUM_REQ byte producers.
// Define UART_ARB_PREFIX_EN to send a PREFIX_BASE+channel byte ahead of each fresh grant.
module uart_tx_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] PREFIX_BASE = 8'h30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  input  logic [NUM_REQ-1:0]       lock,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     tx_start,
  output logic [WIDTH-1:0]         tx_char,
  input  logic                     tx_rdy,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("uart_tx_arbiter: SYNC_STAGES must be at least 1");
  end
  if (int'(PREFIX_BASE) + NUM_REQ > (1 << WIDTH)) begin : g_bad_prefix
    $error("uart_tx_arbiter: PREFIX_BASE + NUM_REQ overflows WIDTH");
  end

`ifdef UART_ARB_PREFIX_EN
  typedef enum logic [2:0] {IDLE, PSEND, PWAIT, SEND, WAIT} state_t;
  logic [WIDTH-1:0] hold_reg;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
`endif

  state_t                 state_reg;
  logic [NUM_REQ-1:0]     ack_reg;
  logic [NUM_REQ-1:0]     grant_reg;
  logic                   tx_start_reg;
  logic [WIDTH-1:0]       tx_char_reg;
  logic [IDX_W-1:0]       ptr_reg;
  logic [IDX_W-1:0]       owner_reg;
  logic [SYNC_STAGES-1:0] rdy_sync_reg;
  logic [SYNC_STAGES-1:0] rdy_sync_next;
  logic [SYNC_STAGES-1:0] primed_reg;
  logic [SYNC_STAGES-1:0] primed_next;
  logic                   rdy_s;
  logic                   primed;

  logic [WIDTH-1:0]       data_arr [NUM_REQ];
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [IDX_W-1:0]       ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The synchronizer resets to "idle line", so its output is not trusted until
  // SYNC_STAGES real samples of tx_rdy have shifted through; primed tracks that.
  always_comb begin
    rdy_sync_next    = rdy_sync_reg << 1;
    rdy_sync_next[0] = tx_rdy;
    primed_next      = primed_reg << 1;
    primed_next[0]   = 1'b1;
  end

  assign rdy_s  = rdy_sync_reg[SYNC_STAGES-1];
  assign primed = primed_reg[SYNC_STAGES-1];

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_reg) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_onehot = NUM_REQ'(1) << winner;
  assign ptr_next   = IDX_W'((int'(owner_reg) + 1) % NUM_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ack_reg      <= '0;
      grant_reg    <= '0;
      tx_start_reg <= 1'b0;
      tx_char_reg  <= '0;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      rdy_sync_reg <= '1;
      primed_reg   <= '0;
`ifdef UART_ARB_PREFIX_EN
      hold_reg     <= '0;
`endif
    end else begin
      rdy_sync_reg <= rdy_sync_next;
      primed_reg   <= primed_next;
      ack_reg      <= '0;
      case (state_reg)
        IDLE: begin
          if (primed && rdy_s && found) begin
            owner_reg    <= winner;
            grant_reg    <= win_onehot;
            ack_reg      <= win_onehot;
            tx_start_reg <= 1'b1;
`ifdef UART_ARB_PREFIX_EN
            hold_reg     <= data_arr[winner];
            tx_char_reg  <= PREFIX_BASE + WIDTH'(winner);
            state_reg    <= PSEND;
`else
            tx_char_reg  <= data_arr[winner];
            state_reg    <= SEND;
`endif
          end
        end
`ifdef UART_ARB_PREFIX_EN
        PSEND: begin
          if (!rdy_s) begin
            tx_start_reg <= 1'b0;
            state_reg    <= PWAIT;
          end
        end
        PWAIT: begin
          if (rdy_s) begin
            tx_char_reg  <= hold_reg;
            tx_start_reg <= 1'b1;
            state_reg    <= SEND;
          end
        end
`endif
        SEND: begin
          if (!rdy_s) begin
            tx_start_reg <= 1'b0;
            state_reg    <= WAIT;
          end
        end
        WAIT: begin
          if (rdy_s) begin
            // A locked owner that still requests keeps the grant without arbitration.
            if (lock[owner_reg] && req[owner_reg]) begin
              tx_char_reg  <= data_arr[owner_reg];
              ack_reg      <= grant_reg;
              tx_start_reg <= 1'b1;
              state_reg    <= SEND;
            end else begin
              grant_reg <= '0;
              ptr_reg   <= ptr_next;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack      = ack_reg;
  assign grant    = grant_reg;
  assign tx_start = tx_start_reg;
  assign tx_char  = tx_char_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART shifter plus a queue-based round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam logic [7:0] PBASE = 8'h30;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   lock;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [W-1:0]   tx_char;
  logic           tx_rdy;
  logic           busy;
  logic           shf_rdy;
  logic           hold_low;

  assign tx_rdy = shf_rdy & ~hold_low;

  always #31 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .SYNC_STAGES(SYNC), .PREFIX_BASE(PBASE)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .lock(lock),
    .ack(ack), .grant(grant), .tx_start(tx_start), .tx_char(tx_char),
    .tx_rdy(tx_rdy), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] prod_q [N][$];
  logic [7:0] exp_frames [$];
  logic [7:0] got_frames [$];
  int         grant_log [$];
  int         m_ptr = 0;
  int         m_owner = -1;
  int         frame_min = 6;
  int         frame_max = 10;

  // Shifter: accepts when ready and new_data is high, then stays busy for one frame.
  initial begin
    shf_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_rdy && tx_start) begin
        got_frames.push_back(tx_char);
        shf_rdy = 1'b0;
        repeat ($urandom_range(frame_max, frame_min)) @(posedge clk);
        #1 shf_rdy = 1'b1;
      end
    end
  end

  function automatic bit queues_pending();
    for (int i = 0; i < N; i++) if (prod_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = (prod_q[i].size() > 0);
      data[i*W +: W] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'($urandom);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] b, input bit fresh);
`ifdef UART_ARB_PREFIX_EN
    if (fresh) exp_frames.push_back(PBASE + 8'(idx));
`else
    if (fresh) begin end
`endif
    exp_frames.push_back(b);
  endtask

  // Next owner from the rules: locked owner continues while it still has bytes,
  // otherwise release (pointer = owner+1) and scan ascending from the pointer.
  function automatic int model_next(output bit fresh);
    if (m_owner >= 0 && lock[m_owner] && prod_q[m_owner].size() > 0) begin
      fresh = 1'b0;
      return m_owner;
    end
    fresh = 1'b1;
    if (m_owner >= 0) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (prod_q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_release();
    if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  task automatic check_frames();
    logic [7:0] g, e;
    vectors++;
    if (got_frames.size() != exp_frames.size()) begin
      miscompares++;
      $display("FAIL frame_count: got %0d frames, want %0d", got_frames.size(), exp_frames.size());
    end
    while (got_frames.size() > 0 && exp_frames.size() > 0) begin
      g = got_frames.pop_front();
      e = exp_frames.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL frame_byte: got %h want %h", g, e);
      end
    end
    got_frames.delete();
    exp_frames.delete();
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 400) begin
      @(posedge clk); #2;
      cyc++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, busy, cyc);
    end
  endtask

  task automatic run_traffic(input int max_cycles);
    int cyc, win;
    bit fresh;
    logic [N-1:0] oh;
    logic [7:0] b;
    cyc = 0;
    drive_req();
    while ((queues_pending() || busy) && cyc < max_cycles) begin
      @(posedge clk); #2;
      cyc++;
      if (ack != '0) begin
        win = model_next(fresh);
        oh = (win >= 0) ? (N'(1) << win) : '0;
        vectors++;
        if (ack !== oh) begin
          miscompares++;
          $display("FAIL traffic_ack: got %b want %b", ack, oh);
        end
        vectors++;
        if (grant !== oh) begin
          miscompares++;
          $display("FAIL traffic_grant: got %b want %b", grant, oh);
        end
        vectors++;
        if (tx_start !== 1'b1 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL traffic_start: tx_start=%b busy=%b want 1 1", tx_start, busy);
        end
        if (win >= 0) begin
          m_owner = win;
          grant_log.push_back(win);
          b = prod_q[win].pop_front();
          push_exp(win, b, fresh);
          $display("txn: req%0d byte %h %s", win, b, fresh ? "fresh" : "locked");
        end
        drive_req();
      end
    end
    vectors++;
    if (cyc >= max_cycles) begin
      miscompares++;
      $display("FAIL traffic_timeout: %0d cycles used, limit %0d", cyc, max_cycles);
    end
    model_release();
    check_frames();
  endtask

  task automatic do_reset();
    req = '0; lock = '0; data = '0;
    for (int i = 0; i < N; i++) prod_q[i].delete();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    m_ptr = 0; m_owner = -1;
    exp_frames.delete(); got_frames.delete(); grant_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; hold_low = 1'b0; req = '0; lock = '0; data = '0;
    repeat (2) @(posedge clk); #2;
    vectors++;
    if ({ack, grant, tx_start, tx_char, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b grant=%b tx_start=%b tx_char=%h busy=%b, want all 0",
               ack, grant, tx_start, tx_char, busy);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk); #2;
    vectors++;
    if (busy !== 1'b0 || grant !== '0 || tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b grant=%b tx_start=%b, want 0 0 0", busy, grant, tx_start);
    end
    $display("txn: reset done");
  endtask

  task automatic test_single();
    logic [7:0] want_char;
    do_reset();
    repeat (SYNC + 2) @(posedge clk); #2;
    req = 4'b0001; data[7:0] = 8'h55;
    @(posedge clk); #2;
`ifdef UART_ARB_PREFIX_EN
    want_char = 8'h30;
`else
    want_char = 8'h55;
`endif
    vectors++;
    if (ack !== 4'b0001 || grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b grant=%b want 0001 0001", ack, grant);
    end
    vectors++;
    if (tx_start !== 1'b1 || busy !== 1'b1 || tx_char !== want_char) begin
      miscompares++;
      $display("FAIL single_tx: tx_start=%b busy=%b tx_char=%h want 1 1 %h", tx_start, busy, tx_char, want_char);
    end
    push_exp(0, 8'h55, 1'b1);
    m_owner = 0;
    req = '0;
    $display("txn: req0 byte 55 single");
    @(posedge clk); #2;
    vectors++;
    if (ack !== 4'b0000 || tx_start !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pulse: ack=%b tx_start=%b want 0000 1", ack, tx_start);
    end
    wait_idle("single");
    model_release();
    check_frames();
  endtask

  task automatic test_round_robin();
    int want [5] = '{0, 1, 2, 3, 0};
    do_reset();
    prod_q[0].push_back(8'($urandom)); prod_q[0].push_back(8'($urandom));
    for (int i = 1; i < N; i++) prod_q[i].push_back(8'($urandom));
    run_traffic(2000);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (k >= grant_log.size() || grant_log[k] != want[k]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", k, (k < grant_log.size()) ? grant_log[k] : -1, want[k]);
      end
    end
  endtask

  task automatic test_lock();
    int want [4] = '{2, 2, 2, 0};
    do_reset();
    prod_q[1].push_back(8'h11);
    run_traffic(1000);
    grant_log.delete();
    prod_q[2].push_back(8'hA1); prod_q[2].push_back(8'hA2); prod_q[2].push_back(8'hA3);
    prod_q[0].push_back(8'h5A);
    lock = 4'b0100;
    run_traffic(2000);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (k >= grant_log.size() || grant_log[k] != want[k]) begin
        miscompares++;
        $display("FAIL lock_order[%0d]: got %0d want %0d", k, (k < grant_log.size()) ? grant_log[k] : -1, want[k]);
      end
    end
    lock = '0;
  endtask

  task automatic wait_grant_after_rdy(input string name, input int since_init);
    int since;
    bit seen;
    since = since_init;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(posedge clk); #2;
      if (since >= 0) since++;
      if (ack != '0) seen = 1'b1;
      else if (tx_rdy && since < 0) since = 0;
    end
    vectors++;
    if (!seen || since != SYNC + 1) begin
      miscompares++;
      $display("FAIL %s_latency: ack seen=%0d, %0d edges after tx_rdy rose, want %0d", name, seen, since, SYNC + 1);
    end
    vectors++;
    if (ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL %s_ack: got %b want 0010", name, ack);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    frame_min = 16; frame_max = 16;
    req = 4'b0010; data[15:8] = 8'hC3;
    cyc = 0;
    while (ack == '0 && cyc < 50) begin @(posedge clk); #2; cyc++; end
    vectors++;
    if (ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_first_ack: got %b want 0010", ack);
    end
    req = '0;
`ifdef UART_ARB_PREFIX_EN
    exp_frames.push_back(PBASE + 8'd1);
`else
    exp_frames.push_back(8'hC3);
`endif
    $display("txn: req1 byte c3 before reset");
    cyc = 0;
    while (!(tx_start == 1'b0 && busy == 1'b1) && cyc < 50) begin @(posedge clk); #2; cyc++; end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (tx_start !== 1'b0 || grant !== '0 || ack !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: tx_start=%b grant=%b ack=%b busy=%b want all 0", tx_start, grant, ack, busy);
    end
    check_frames();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    m_ptr = 0; m_owner = -1;
    req = 4'b0010; data[15:8] = 8'h3C;
    wait_grant_after_rdy("midrst", -1);
    push_exp(1, 8'h3C, 1'b1);
    m_owner = 1;
    req = '0;
    $display("txn: req1 byte 3c after reset");
    wait_idle("midrst");
    model_release();
    check_frames();
    frame_min = 6; frame_max = 10;
  endtask

  task automatic test_rdy_low_at_reset();
    int early;
    hold_low = 1'b1;
    do_reset();
    req = 4'b0010; data[15:8] = 8'h96;
    early = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (ack != '0) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++;
      $display("FAIL rdylow_early_ack: %0d acks while tx_rdy low, want 0", early);
    end
    hold_low = 1'b0;
    wait_grant_after_rdy("rdylow", 0);
    push_exp(1, 8'h96, 1'b1);
    m_owner = 1;
    req = '0;
    $display("txn: req1 byte 96 after rdy release");
    wait_idle("rdylow");
    model_release();
    check_frames();
  endtask

`ifdef UART_ARB_PREFIX_EN
  task automatic test_prefix();
    do_reset();
    prod_q[3].push_back(8'h41);
    run_traffic(1000);
    vectors++;
    if (grant_log.size() != 1) begin
      miscompares++;
      $display("FAIL prefix_ack_count: got %0d acks want 1", grant_log.size());
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 20; t++) begin
      lock = N'($urandom);
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(3, 0);
        for (int j = 0; j < n; j++) prod_q[i].push_back(8'($urandom));
      end
      run_traffic(4000);
    end
    lock = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_reset_mid();
    test_rdy_low_at_reset();
`ifdef UART_ARB_PREFIX_EN
    test_prefix();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
